seg_pipe_addsub: RTL and testbench
==================================

Name: seg_pipe_addsub

Overview:
- Parametrised, pipelined two's-complement adder/subtractor.
- The N-bit operation is split into SEG-bit segments. One segment is resolved per pipeline stage, and the carry is registered between stages.
- Sits in the arithmetic library as the wide, high-Fmax successor to the single-cycle add/sub. It adds a valid/ready stream interface, backpressure, per-op mode, carry-out and signed overflow.
- Throughput: one operation per cycle.

Parameters:
- N, 32, operand/result width in bits; N must be a multiple of SEG and N >= 2.
- SEG, 8, segment width resolved per stage; 1 <= SEG <= N.
- Derived localparam STAGES = N/SEG, which is the pipeline depth and latency.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset.
- in_valid  input  1  operation offered.
- in_ready  output  1  block accepts an operation this cycle.
- a  input  N  operand A.
- b  input  N  operand B.
- sub  input  1  1 = A-B, 0 = A+B; sampled with the operands.
- out_valid  output  1  result presented.
- out_ready  input  1  downstream accepts the result.
- out  output  N  result.
- cout  output  1  unsigned carry out of bit N-1 (for sub: 1 = no borrow).
- ovf  output  1  signed overflow.

Interface rule: one clock; reset is asynchronous and active-low.

Behaviour:
- **Reset:** asserting rst_n low immediately clears all stage valid bits, out_valid, out, cout and ovf to 0.
  - in_ready reads 1 in reset and after release.
  - Reset mid-operation discards all in-flight operations; no partial result is ever emitted.
- **Advance:** adv = !out_valid || out_ready. All stages shift together on adv; no stage moves when adv = 0.
  - in_ready = adv, purely combinational from out_valid/out_ready.
- **Accept:** an op is taken when in_valid && in_ready. A, B ^ {N{sub}} and sub (as carry-in) are registered into stage 0.
  - Stage valid bits propagate empty bubbles when in_valid = 0.
- **Stage k (0..STAGES-1):**
  - Computes {c[k+1], r_seg_k} = a_seg_k + bx_seg_k + c[k], where c[0] = sub.
  - Registers c[k+1], the lower result segments produced so far, and the still-unprocessed upper operand segments.
  - Operand segments already consumed are not carried forward.
- **Final stage:**
  - ovf = carry into bit N-1 XOR carry out of bit N-1. When SEG = 1, the carry into bit N-1 is the stage input carry; otherwise it is computed within the last segment.
  - cout = carry out of bit N-1.
  - out, cout and ovf are registered together with out_valid.
- **Latency:** a result is valid exactly STAGES cycles after acceptance if never stalled. Each stalled cycle adds one.
- **Output hold:** while out_valid && !out_ready, out, cout and ovf are held stable and in_ready = 0.
- **Simultaneous events:** out_ready = 1 with out_valid = 1 and in_valid = 1 retires one result and accepts one op in the same cycle, giving full throughput.
- **Ordering:** results emerge in acceptance order; no reordering, drop or duplication.
- **Degenerate case:** SEG = N gives a single-stage registered add/sub with latency 1.
- **Arithmetic:** N-bit modulo results (wrap) unless the optional feature is compiled in. Sub is A + ~B + 1.

Optional Feature:
- Macro: SEG_PIPE_ADDSUB_SAT_EN.
- **Defined:** when ovf = 1, out is clamped to the signed limit.
  - Positive overflow gives {1'b0,{N-1{1'b1}}}; negative overflow gives {1'b1,{N-1{1'b0}}}.
  - Direction is taken from the sign of A, since overflow only occurs when the effective operands share a sign.
  - ovf and cout are still reported unmodified. The clamp sits in the final stage and adds no latency.
- **Undefined:** out wraps; there is no clamp logic.

Test Plan (N=8, SEG=4, latency 2 unless noted):
- Cross-segment carry: a=0x0F, b=0x01, sub=0 -> out=0x10, cout=0, ovf=0, out_valid exactly 2 cycles after accept. Then a=0xFF, b=0x01 -> out=0x00, cout=1, ovf=0.
- Signed overflow: a=0x7F, b=0x01, sub=0 -> out=0x80, ovf=1 (SAT_EN: out=0x7F). Then a=0x80, b=0x01, sub=1 -> out=0x7F, ovf=1, cout=1 (SAT_EN: out=0x80).
- Borrow: a=0x00, b=0x01, sub=1 -> out=0xFF, cout=0, ovf=0.
- Backpressure: stream 10 random ops with in_valid held 1 and out_ready toggled 1,0,0,0,1… -> in_ready=0 exactly when out_valid && !out_ready. out is stable during stalls. All 10 results match the reference model in order.
- Reset mid-flight: accept 2 ops, assert rst_n low asynchronously between clock edges -> out_valid/out/cout/ovf go 0 without a clock edge. After release no stale result appears; the next op completes with latency 2.
- Degenerate configs: N=8, SEG=8 gives latency 1. N=8, SEG=1 gives latency 8, with 0x7F+0x01 -> ovf=1. Back-to-back ops at full throughput in both.

Source files
------------

// File: rtl/seg_pipe_addsub.sv
// Pipelined two's-complement adder/subtractor: one SEG-bit segment per stage, carry registered between stages.
// Optional signed saturation of the result is compiled in with SEG_PIPE_ADDSUB_SAT_EN.
module seg_pipe_addsub #(
  parameter int N   = 32,
  parameter int SEG = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic         cout,
  output logic         ovf
);

  localparam int STAGES = N / SEG;

  // Handshake: the whole pipe advances together whenever the output slot is
  // empty or being drained; an op is accepted on in_valid && in_ready.
  logic         adv;
  logic [N-1:0] bx_in;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign bx_in    = b ^ {N{sub}};

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO   = k * SEG;
      localparam int DONE = (k + 1) * SEG;

      // a_cur/bx_cur hold the operand bits not yet consumed; the low segment is resolved here.
      logic [N-LO-1:0] a_cur;
      logic [N-LO-1:0] bx_cur;
      logic            cin;
      logic            v_in;
      logic [SEG:0]    sum;
      logic [DONE-1:0] res_d;
      logic [DONE-1:0] res_next;
      logic [DONE-1:0] res_q;
      logic            v_q;
      logic            c_q;

      if (k == 0) begin : g_src
        assign a_cur  = a;
        assign bx_cur = bx_in;
        assign cin    = sub;
        assign v_in   = in_valid;
        assign res_d  = sum[SEG-1:0];
      end else begin : g_src
        assign a_cur  = g_stage[k-1].g_ops.a_q;
        assign bx_cur = g_stage[k-1].g_ops.bx_q;
        assign cin    = g_stage[k-1].c_q;
        assign v_in   = g_stage[k-1].v_q;
        assign res_d  = {sum[SEG-1:0], g_stage[k-1].res_q};
      end

      assign sum = {1'b0, a_cur[SEG-1:0]} + {1'b0, bx_cur[SEG-1:0]} + {{SEG{1'b0}}, cin};

      if (k < STAGES - 1) begin : g_ops
        logic [N-DONE-1:0] a_q;
        logic [N-DONE-1:0] bx_q;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            a_q  <= '0;
            bx_q <= '0;
          end else if (adv && v_in) begin
            a_q  <= a_cur[N-LO-1:SEG];
            bx_q <= bx_cur[N-LO-1:SEG];
          end
        end
      end

      if (k == STAGES - 1) begin : g_last
        logic carry_msb;
        logic ovf_d;
        logic ovf_q;

        // Carry into bit N-1 recovered from the MSB sum bit; equals cin when SEG = 1.
        assign carry_msb = sum[SEG-1] ^ a_cur[SEG-1] ^ bx_cur[SEG-1];
        assign ovf_d     = carry_msb ^ sum[SEG];

`ifdef SEG_PIPE_ADDSUB_SAT_EN
        localparam logic [N-1:0] POS_LIM = {1'b0, {(N-1){1'b1}}};
        localparam logic [N-1:0] NEG_LIM = {1'b1, {(N-1){1'b0}}};

        // Overflow needs like-signed effective operands, so A's sign gives the direction.
        assign res_next = ovf_d ? (a_cur[SEG-1] ? NEG_LIM : POS_LIM) : res_d;
`else
        assign res_next = res_d;
`endif

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            ovf_q <= 1'b0;
          end else if (adv && v_in) begin
            ovf_q <= ovf_d;
          end
        end
      end else begin : g_mid
        assign res_next = res_d;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q   <= 1'b0;
          c_q   <= 1'b0;
          res_q <= '0;
        end else if (adv) begin
          v_q <= v_in;
          if (v_in) begin
            c_q   <= sum[SEG];
            res_q <= res_next;
          end
        end
      end
    end
  endgenerate

  assign out_valid = g_stage[STAGES-1].v_q;
  assign out       = g_stage[STAGES-1].res_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_seg_pipe_addsub.sv
// Bench for seg_pipe_addsub: N=8 with SEG=4 (main), SEG=8 and SEG=1 (degenerate depths).
// Expected values come from hand-computed tables and a behavioural add/sub model.
module tb_seg_pipe_addsub;

  localparam int W = 8;
`ifdef SEG_PIPE_ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] out;
    logic         cout;
    logic         ovf;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- main DUT (SEG=4, latency 2) ----------------
  logic         in_valid, in_ready, sub, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, out;

  seg_pipe_addsub #(.N(W), .SEG(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .cout(cout), .ovf(ovf)
  );

  // ---------------- degenerate DUTs (SEG=8 latency 1, SEG=1 latency 8) ----------------
  logic         d_valid, d_sub, d_ready;
  logic [W-1:0] d_a, d_b;
  logic         s8_in_ready, s8_valid, s8_cout, s8_ovf;
  logic         s1_in_ready, s1_valid, s1_cout, s1_ovf;
  logic [W-1:0] s8_out, s1_out;

  seg_pipe_addsub #(.N(W), .SEG(8)) dut_s8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(d_valid), .in_ready(s8_in_ready),
    .a(d_a), .b(d_b), .sub(d_sub),
    .out_valid(s8_valid), .out_ready(d_ready),
    .out(s8_out), .cout(s8_cout), .ovf(s8_ovf)
  );

  seg_pipe_addsub #(.N(W), .SEG(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(d_valid), .in_ready(s1_in_ready),
    .a(d_a), .b(d_b), .sub(d_sub),
    .out_valid(s1_valid), .out_ready(d_ready),
    .out(s1_out), .cout(s1_cout), .ovf(s1_ovf)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W+1:0] exp_q[$];
  logic [W+1:0] exp8_q[$];
  logic [W+1:0] exp1_q[$];
  int           t8_q[$];
  int           t1_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: {out, cout, ovf}
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic msub);
    logic [W-1:0] bx;
    logic [W:0]   s;
    logic         v;
    logic [W-1:0] r;
    bx = msub ? ~mb : mb;
    s  = {1'b0, ma} + {1'b0, bx} + {{W{1'b0}}, msub};
    v  = (ma[W-1] == bx[W-1]) && (s[W-1] != ma[W-1]);
    r  = s[W-1:0];
    if (SAT && v) r = ma[W-1] ? 8'h80 : 8'h7F;
    return {r, s[W], v};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_one(input vec_t v, input string tag);
    int cyc;
    @(negedge clk);
    in_valid = 1'b1;
    a = v.a;
    b = v.b;
    sub = v.sub;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("%s_latency", tag), 32'(cyc), 32'd2);
    check($sformatf("%s_out", tag), 32'(out), 32'(v.out));
    check($sformatf("%s_cout", tag), 32'(cout), 32'(v.cout));
    check($sformatf("%s_ovf", tag), 32'(ovf), 32'(v.ovf));
  endtask

  vec_t         tbl[8];
  logic [W-1:0] bp_a[10];
  logic [W-1:0] bp_b[10];
  logic         bp_sub[10];
  logic [W-1:0] dg_a[8];
  logic [W-1:0] dg_b[8];
  logic         dg_sub[8];

  initial begin
    int sent, got, r8, r1;
    logic m_v0, m_v1, exp_rdy, stall_prev;
    logic [W+1:0] held, e;

    tbl[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h7F, 8'h01, 1'b0, (SAT ? 8'h7F : 8'h80), 1'b0, 1'b1};
    tbl[3] = '{8'h80, 8'h01, 1'b1, (SAT ? 8'h80 : 8'h7F), 1'b1, 1'b1};
    tbl[4] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[5] = '{8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0};
    tbl[6] = '{8'h80, 8'h80, 1'b0, (SAT ? 8'h80 : 8'h00), 1'b1, 1'b1};
    tbl[7] = '{8'h3C, 8'h0C, 1'b0, 8'h48, 1'b0, 1'b0};

    for (int i = 0; i < 10; i++) begin
      bp_a[i]   = 8'($urandom_range(0, 255));
      bp_b[i]   = 8'($urandom_range(0, 255));
      bp_sub[i] = 1'($urandom_range(0, 1));
    end
    dg_a[0] = 8'h7F; dg_b[0] = 8'h01; dg_sub[0] = 1'b0;
    dg_a[1] = 8'h0F; dg_b[1] = 8'h01; dg_sub[1] = 1'b0;
    dg_a[2] = 8'h80; dg_b[2] = 8'h01; dg_sub[2] = 1'b1;
    dg_a[3] = 8'h00; dg_b[3] = 8'h01; dg_sub[3] = 1'b1;
    dg_a[4] = 8'hFF; dg_b[4] = 8'h01; dg_sub[4] = 1'b0;
    for (int i = 5; i < 8; i++) begin
      dg_a[i]   = 8'($urandom_range(0, 255));
      dg_b[i]   = 8'($urandom_range(0, 255));
      dg_sub[i] = 1'($urandom_range(0, 1));
    end

    // ---- reset state ----
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
    d_valid = 1'b0; d_a = '0; d_b = '0; d_sub = 1'b0; d_ready = 1'b1;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);

    // ---- directed vectors, one op at a time ----
    for (int i = 0; i < 8; i++) apply_one(tbl[i], $sformatf("vec%0d", i));

    // ---- backpressure: out_ready 1,0,0,0 repeating, in_valid held ----
    sent = 0; got = 0; m_v0 = 1'b0; m_v1 = 1'b0; stall_prev = 1'b0; held = '0;
    for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
      @(negedge clk);
      out_ready = (cyc % 4 == 0);
      if (sent < 10) begin
        in_valid = 1'b1; a = bp_a[sent]; b = bp_b[sent]; sub = bp_sub[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      exp_rdy = !m_v1 || out_ready;
      check("bp_out_valid", 32'(out_valid), 32'(m_v1));
      check("bp_in_ready", 32'(in_ready), 32'(exp_rdy));
      if (stall_prev) check("bp_hold", 32'({out, cout, ovf}), 32'(held));
      if (m_v1 && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check($sformatf("bp_result%0d", got), 32'({out, cout, ovf}), 32'(e));
        got++;
      end
      if (in_valid && exp_rdy) begin
        exp_q.push_back(model(a, b, sub));
        sent++;
      end
      if (exp_rdy) begin
        m_v1 = m_v0;
        m_v0 = in_valid;
      end
      stall_prev = m_v1 && !out_ready && !exp_rdy;
      stall_prev = out_valid && !out_ready;
      held = {out, cout, ovf};
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp_result_count", 32'(got), 32'd10);

    // ---- degenerate depths, back-to-back ops ----
    r8 = 0; r1 = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      @(negedge clk);
      if (cyc < 8) begin
        d_valid = 1'b1; d_a = dg_a[cyc]; d_b = dg_b[cyc]; d_sub = dg_sub[cyc];
      end else begin
        d_valid = 1'b0;
      end
      #1;
      if (cyc < 8) begin
        check("s8_in_ready", 32'(s8_in_ready), 32'd1);
        check("s1_in_ready", 32'(s1_in_ready), 32'd1);
      end
      if (s8_valid) begin
        if (exp8_q.size() == 0) check("s8_spurious", 32'd1, 32'd0);
        else begin
          check($sformatf("s8_result%0d", r8), 32'({s8_out, s8_cout, s8_ovf}), 32'(exp8_q.pop_front()));
          check($sformatf("s8_latency%0d", r8), 32'(cyc - t8_q.pop_front()), 32'd1);
          r8++;
        end
      end
      if (s1_valid) begin
        if (exp1_q.size() == 0) check("s1_spurious", 32'd1, 32'd0);
        else begin
          check($sformatf("s1_result%0d", r1), 32'({s1_out, s1_cout, s1_ovf}), 32'(exp1_q.pop_front()));
          check($sformatf("s1_latency%0d", r1), 32'(cyc - t1_q.pop_front()), 32'd8);
          r1++;
        end
      end
      if (d_valid) begin
        exp8_q.push_back(model(d_a, d_b, d_sub));
        exp1_q.push_back(model(d_a, d_b, d_sub));
        t8_q.push_back(cyc);
        t1_q.push_back(cyc);
      end
    end
    check("s8_result_count", 32'(r8), 32'd8);
    check("s1_result_count", 32'(r1), 32'd8);

    // ---- asynchronous reset with ops in flight ----
    @(negedge clk);
    in_valid = 1'b1; a = 8'h7F; b = 8'h01; sub = 1'b0;
    @(negedge clk);
    a = 8'h12; b = 8'h34;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    check("pre_rst_out", 32'({out, cout, ovf}), 32'(model(8'h7F, 8'h01, 1'b0)));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_out", 32'(out), 32'd0);
    check("async_rst_ovf", 32'(ovf), 32'd0);
    check("async_rst_cout", 32'(cout), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_stale_result", 32'(out_valid), 32'd0);
    end
    apply_one(tbl[5], "post_rst");

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
